// File: rtl/adder_share_arbiter_pkg.sv
// Shared constants for the adder-sharing arbiter: FSM encoding and operand width.
package adder_share_arbiter_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Request/response bundle between client blocks and the adder-sharing arbiter.
interface adder_share_arbiter_if
    import adder_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int CNT_W   = 16
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       req_valid;
    logic [NIB_W*NUM_REQ-1:0] req_a;
    logic [NIB_W*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     resp_valid;
    logic [IDW-1:0]           resp_id;
    logic [NIB_W-1:0]         resp_sum;
    logic                     resp_cout;
    logic                     resp_ready;
    logic [CNT_W-1:0]         op_count;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_sum, resp_cout, op_count
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_sum, resp_cout, op_count
    );

endinterface

// File: rtl/adder_share_arbiter_rr_pick.sv
// Round-robin selector: first valid index strictly after i_last, wrapping.
module adder_share_arbiter_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDW     = 1
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IDW-1:0]     i_last,
    output logic [IDW-1:0]     o_gnt,
    output logic               o_any
);
    int w_idx;

    always_comb begin
        o_gnt = '0;
        o_any = 1'b0;
        w_idx = 0;
        // k = NUM_REQ wraps back to i_last itself, so a lone requester still wins
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = (int'(i_last) + k) % NUM_REQ;
            if (!o_any && i_valid[w_idx]) begin
                o_any = 1'b1;
                o_gnt = w_idx[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/four_bits_full_adder.sv
// 4-bit ripple-carry adder datapath shared by the arbiter clients.
module four_bits_full_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);
    logic [4:0] w_c;

    always_comb begin
        w_c    = '0;
        sum    = '0;
        w_c[0] = c_in;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ w_c[i];
            w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
    end

    assign c_out = w_c[4];

endmodule

// File: rtl/adder_share_arbiter.sv
// Time-shares one 4-bit adder among NUM_REQ clients: round-robin grant,
// operand capture, registered result with valid/ready return, and an op counter.
module adder_share_arbiter
    import adder_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    adder_share_arbiter_if.slave bus
);
    //  state   | meaning
    //  IDLE    | arbitrate; grant strobe and operand capture
    //  CALC    | adder evaluates captured operands; result registered
    //  RESP    | result presented until the consumer accepts it
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t           r_state;
    state_t           w_next;
    logic [IDW-1:0]   r_last_gnt;
    logic [IDW-1:0]   r_id;
    logic [IDW-1:0]   r_resp_id;
    logic [NIB_W-1:0] r_op_a;
    logic [NIB_W-1:0] r_op_b;
    logic [NIB_W-1:0] r_resp_sum;
    logic             r_resp_cout;
    logic [CNT_W-1:0] r_op_count;
    logic [IDW-1:0]   w_gnt;
    logic             w_any;
    logic [NIB_W-1:0] w_sum;
    logic             w_cout;
    logic             w_accept;
    logic             w_done;

    adder_share_arbiter_rr_pick #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_pick (
        .i_valid (bus.req_valid),
        .i_last  (r_last_gnt),
        .o_gnt   (w_gnt),
        .o_any   (w_any)
    );

    four_bits_full_adder u_add (
        .a     (r_op_a),
        .b     (r_op_b),
        .c_in  (1'b0),
        .sum   (w_sum),
        .c_out (w_cout)
    );

    // Gating with rst keeps the grant strobe quiet during a reset cycle.
    assign w_accept = (r_state == ST_IDLE) && w_any && !rst;
    assign w_done   = (r_state == ST_RESP) && bus.resp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_any) w_next = ST_CALC;
            ST_CALC: w_next = ST_RESP;
            ST_RESP: if (bus.resp_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = '0;
        bus.resp_valid = 1'b0;
        if (w_accept) begin
            bus.req_ready[w_gnt] = 1'b1;
        end
        if (r_state == ST_RESP) begin
            bus.resp_valid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_gnt  <= IDW'(NUM_REQ - 1);
            r_id        <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_resp_id   <= '0;
            r_resp_sum  <= '0;
            r_resp_cout <= 1'b0;
            r_op_count  <= '0;
        end else begin
            if (w_accept) begin
                r_last_gnt <= w_gnt;
                r_id       <= w_gnt;
                r_op_a     <= bus.req_a[int'(w_gnt)*NIB_W +: NIB_W];
                r_op_b     <= bus.req_b[int'(w_gnt)*NIB_W +: NIB_W];
            end
            if (r_state == ST_CALC) begin
                r_resp_id   <= r_id;
                r_resp_sum  <= w_sum;
                r_resp_cout <= w_cout;
            end
            if (w_done) begin
                r_op_count <= r_op_count + 1'b1;
            end
        end
    end

    assign bus.resp_id   = r_resp_id;
    assign bus.resp_sum  = r_resp_sum;
    assign bus.resp_cout = r_resp_cout;
    assign bus.op_count  = r_op_count;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter with an expected-result queue.
module tb_adder_share_arbiter;
    import adder_share_arbiter_pkg::*;

    localparam int NR = 2;
    localparam int CW = 16;

    typedef struct packed {
        logic       id;
        logic       cout;
        logic [3:0] sum;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adder_share_arbiter_if #(.NUM_REQ(NR), .CNT_W(CW)) bus ();

    adder_share_arbiter #(.NUM_REQ(NR), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_vec   = 0;
    int   n_err   = 0;
    int   exp_cnt = 0;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int id, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        exp_t       e;
        s      = {1'b0, a} + {1'b0, b};
        e.id   = id[0];
        e.cout = s[4];
        e.sum  = s[3:0];
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b1;
        bus.req_valid  = '0;
        bus.resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        exp_cnt = 0;
    endtask

    // Waits for a response, compares it with the queue head, optionally holds
    // backpressure for 'hold' cycles, then accepts it.
    task automatic wait_resp(input int hold, input int t_acc, input bit chk_lat,
                             input logic [NR-1:0] bp_mask);
        int         n;
        exp_t       e;
        logic [3:0] s0;
        logic       id0;
        n = 0;
        while (!bus.resp_valid && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check("resp_arrives", 32'(bus.resp_valid), 32'd1);
        if (bus.resp_valid) begin
            if (chk_lat) check("latency", 32'(cyc - t_acc), 32'd2);
            check("sb_depth", 32'(sb.size()), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("resp_id",   32'(bus.resp_id),   32'(e.id));
                check("resp_cout", 32'(bus.resp_cout), 32'(e.cout));
                check("resp_sum",  32'(bus.resp_sum),  32'(e.sum));
            end
            s0  = bus.resp_sum;
            id0 = bus.resp_id;
            bus.req_valid = bp_mask;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk); #1;
                check("bp_valid",   32'(bus.resp_valid), 32'd1);
                check("bp_sum",     32'(bus.resp_sum),   32'(s0));
                check("bp_id",      32'(bus.resp_id),    32'(id0));
                check("bp_noready", 32'(bus.req_ready),  32'd0);
            end
            bus.req_valid  = '0;
            bus.resp_ready = 1'b1;
            @(negedge clk); #1;
            bus.resp_ready = 1'b0;
            exp_cnt++;
            check("resp_dropped", 32'(bus.resp_valid), 32'd0);
            check("op_count",     32'(bus.op_count),   32'(exp_cnt));
        end
    endtask

    task automatic do_op(input int id, input logic [3:0] a, input logic [3:0] b,
                         input int hold, input logic [NR-1:0] bp_mask);
        int n;
        int t_acc;
        bus.req_valid          = '0;
        bus.req_valid[id]      = 1'b1;
        bus.req_a[id*4 +: 4]   = a;
        bus.req_b[id*4 +: 4]   = b;
        #1;
        n = 0;
        while (bus.req_ready == '0 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check("grant", 32'(bus.req_ready), 32'(1 << id));
        t_acc = cyc;
        push_exp(id, a, b);
        @(negedge clk);
        bus.req_valid = '0;
        bus.req_a     = ~bus.req_a;
        bus.req_b     = ~bus.req_b;
        wait_resp(hold, t_acc, 1'b1, bp_mask);
    endtask

    initial begin
        int   ngr;
        int   last_t;
        exp_t e;

        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b0;
        rst            = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_ready", 32'(bus.req_ready),  32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_id",   32'(bus.resp_id),    32'd0);
        check("rst_resp_sum",  32'(bus.resp_sum),   32'd0);
        check("rst_resp_cout", 32'(bus.resp_cout),  32'd0);
        check("rst_op_count",  32'(bus.op_count),   32'd0);

        // resp_ready while idle must not count anything
        @(negedge clk);
        rst            = 1'b0;
        bus.resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("idle_rdy_count", 32'(bus.op_count),   32'd0);
        check("idle_rdy_valid", 32'(bus.resp_valid), 32'd0);
        bus.resp_ready = 1'b0;
        @(negedge clk);

        // single request and overflow cases
        do_op(0, 4'd3, 4'd4, 0, '0);
        do_op(1, 4'd15, 4'd15, 0, '0);
        do_op(1, 4'd8, 4'd8, 0, '0);

        // backpressure with a competing request pending
        do_op(0, 4'd9, 4'd5, 5, 2'b10);

        // fairness: both requesting, consumer always ready
        do_reset();
        bus.req_a      = {4'd9, 4'd1};
        bus.req_b      = {4'd9, 4'd2};
        bus.req_valid  = 2'b11;
        bus.resp_ready = 1'b1;
        #1;
        ngr    = 0;
        last_t = 0;
        for (int i = 0; i < 40; i++) begin
            if (ngr == 4) bus.req_valid = '0;
            if (bus.req_ready != '0) begin
                check("fair_grant", 32'(bus.req_ready), 32'(1 << (ngr % 2)));
                if (ngr > 0) check("fair_spacing", 32'(cyc - last_t), 32'd3);
                last_t = cyc;
                if (ngr % 2 == 0) push_exp(0, 4'd1, 4'd2);
                else              push_exp(1, 4'd9, 4'd9);
                ngr++;
            end
            if (bus.resp_valid) begin
                check("fair_sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("fair_id",   32'(bus.resp_id),   32'(e.id));
                    check("fair_cout", 32'(bus.resp_cout), 32'(e.cout));
                    check("fair_sum",  32'(bus.resp_sum),  32'(e.sum));
                    exp_cnt++;
                end
            end
            @(negedge clk); #1;
            if (ngr == 4 && sb.size() == 0) break;
        end
        bus.resp_ready = 1'b0;
        check("fair_ngrants", 32'(ngr), 32'd4);
        check("fair_drained", 32'(sb.size()), 32'd0);
        check("fair_count",   32'(bus.op_count), 32'(exp_cnt));

        // reset during CALC aborts the operation and reinitialises the pointer
        do_reset();
        do_op(0, 4'd2, 4'd3, 0, '0);
        bus.req_valid    = 2'b01;
        bus.req_a[3:0]   = 4'd5;
        bus.req_b[3:0]   = 4'd6;
        #1;
        check("abort_grant", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = '0;
        rst = 1'b1;
        @(negedge clk); #1;
        check("abort_valid", 32'(bus.resp_valid), 32'd0);
        check("abort_count", 32'(bus.op_count),   32'd0);
        bus.req_valid = 2'b11;
        bus.req_a     = {4'd1, 4'd7};
        bus.req_b     = {4'd1, 4'd8};
        #1;
        check("rst_cycle_noready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        exp_cnt = 0;
        #1;
        check("post_rst_grant", 32'(bus.req_ready), 32'd1);
        last_t = cyc;
        push_exp(0, 4'd7, 4'd8);
        @(negedge clk);
        bus.req_valid = '0;
        wait_resp(0, last_t, 1'b1, '0);

        // exhaustive operand sweep through requester 0
        do_reset();
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_op(0, 4'(a), 4'(b), 0, '0);
            end
        end
        check("sweep_count", 32'(bus.op_count), 32'd256);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
